// File: rtl/fme_pkg.sv
// Shared definitions for the fractional motion-estimation SAD selector:
// FSM states, candidate indices and accumulator sizing.
package fme_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StCmp,
    StDone
  } fme_state_e;

  localparam logic [1:0] CAND_A = 2'd0;
  localparam logic [1:0] CAND_B = 2'd1;
  localparam logic [1:0] CAND_C = 2'd2;

  // Eight samples per row add 3 bits; up to eight rows add 3 more.
  function automatic int unsigned row_sad_width(input int unsigned dw);
    return dw + 3;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw);
    return dw + 6;
  endfunction

endpackage

// File: rtl/sad_row8.sv
// Combinational SAD of one 8-sample row: eight absolute differences
// reduced by a three-level adder tree.
module sad_row8 #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic [8*DATAWIDTH-1:0] cand,
  input  logic [8*DATAWIDTH-1:0] orig,
  output logic [DATAWIDTH+2:0]   sad
);

  logic [7:0][DATAWIDTH-1:0] diff;
  logic [3:0][DATAWIDTH:0]   sum1;
  logic [1:0][DATAWIDTH+1:0] sum2;

  always_comb begin
    diff = '0;
    for (int k = 0; k < 8; k++) begin
      if (cand[k*DATAWIDTH +: DATAWIDTH] >= orig[k*DATAWIDTH +: DATAWIDTH]) begin
        diff[k] = cand[k*DATAWIDTH +: DATAWIDTH] - orig[k*DATAWIDTH +: DATAWIDTH];
      end else begin
        diff[k] = orig[k*DATAWIDTH +: DATAWIDTH] - cand[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    sum1 = '0;
    sum2 = '0;
    for (int i = 0; i < 4; i++) begin
      sum1[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      sum2[i] = {1'b0, sum1[2*i]} + {1'b0, sum1[2*i+1]};
    end
    sad = {1'b0, sum2[0]} + {1'b0, sum2[1]};
  end

endmodule

// File: rtl/fme_sad_selector.sv
// Accumulates row SADs of three interpolated candidates over one block and
// reports the cheapest. Optional FME_SAD_PROTOCOL_CHECK_EN adds proto_err.
module fme_sad_selector
  import fme_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ROWS      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   valid,
  input  logic [8*DATAWIDTH-1:0] cand_a,
  input  logic [8*DATAWIDTH-1:0] cand_b,
  input  logic [8*DATAWIDTH-1:0] cand_c,
  input  logic [8*DATAWIDTH-1:0] orig,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             best_idx,
  output logic [DATAWIDTH+5:0]   best_sad
`ifdef FME_SAD_PROTOCOL_CHECK_EN
  ,
  output logic                   proto_err
`endif
);

  localparam int unsigned AccW = acc_width(DATAWIDTH);
  localparam int unsigned RowW = row_sad_width(DATAWIDTH);
  localparam int unsigned CntW = $clog2(ROWS + 1);

  fme_state_e             state_q, state_d;
  logic [2:0][AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             best_idx_q, best_idx_d;
  logic [AccW-1:0]        best_sad_q, best_sad_d;
  logic [2:0][RowW-1:0]   row_sad;
  logic [2:0][8*DATAWIDTH-1:0] cands;

  assign cands[0] = cand_a;
  assign cands[1] = cand_b;
  assign cands[2] = cand_c;

  for (genvar i = 0; i < 3; i++) begin : gen_sad
    sad_row8 #(
      .DATAWIDTH(DATAWIDTH)
    ) u_sad_row8 (
      .cand(cands[i]),
      .orig(orig),
      .sad (row_sad[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_sad_d = best_sad_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StAcc: begin
        if (valid) begin
          for (int i = 0; i < 3; i++) begin
            acc_d[i] = acc_q[i] + AccW'(row_sad[i]);
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ROWS - 1)) begin
            state_d = StCmp;
          end
        end
      end
      StCmp: begin
        // Strict less-than keeps the lowest index on ties.
        best_idx_d = CAND_A;
        best_sad_d = acc_q[0];
        if (acc_q[1] < best_sad_d) begin
          best_idx_d = CAND_B;
          best_sad_d = acc_q[1];
        end
        if (acc_q[2] < best_sad_d) begin
          best_idx_d = CAND_C;
          best_sad_d = acc_q[2];
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_sad_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_sad_q <= best_sad_d;
    end
  end

  assign busy     = (state_q == StAcc) || (state_q == StCmp);
  assign done     = (state_q == StDone);
  assign best_idx = best_idx_q;
  assign best_sad = best_sad_q;

`ifdef FME_SAD_PROTOCOL_CHECK_EN
  logic proto_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= (start && (state_q != StIdle)) ||
                     (valid && ((state_q == StCmp) || (state_q == StDone)));
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_fme_sad_selector.sv
// Randomized self-checking bench for fme_sad_selector against a per-pixel
// arithmetic reference of the three candidate SADs.
module tb_fme_sad_selector;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        valid;
  logic [63:0] cand_a, cand_b, cand_c, orig;
  logic        busy, done;
  logic [1:0]  best_idx;
  logic [13:0] best_sad;
`ifdef FME_SAD_PROTOCOL_CHECK_EN
  logic        proto_err;
`endif

  always #5 clock = ~clock;

  fme_sad_selector #(
    .DATAWIDTH(8),
    .ROWS     (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .valid   (valid),
    .cand_a  (cand_a),
    .cand_b  (cand_b),
    .cand_c  (cand_c),
    .orig    (orig),
    .busy    (busy),
    .done    (done),
    .best_idx(best_idx),
    .best_sad(best_sad)
`ifdef FME_SAD_PROTOCOL_CHECK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] pa[8][8];
  logic [7:0] pb[8][8];
  logic [7:0] pc[8][8];
  logic [7:0] po[8][8];
  int exp_idx, exp_sad;
  int save_idx, save_sad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble();
    cand_a = {$urandom, $urandom};
    cand_b = {$urandom, $urandom};
    cand_c = {$urandom, $urandom};
    orig   = {$urandom, $urandom};
  endtask

  // 0 random, 1 a=o+1/b=o/c=o+3, 2 all o+1, 3 o=0 all 255, 4 near-o, 5 b=c tie
  task automatic gen(input int mode);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        int o;
        case (mode)
          1: o = $urandom_range(0, 252);
          2: o = $urandom_range(0, 254);
          3: o = 0;
          4: o = $urandom_range(1, 254);
          5: o = $urandom_range(0, 253);
          default: o = $urandom_range(0, 255);
        endcase
        po[r][k] = 8'(o);
        case (mode)
          1: begin pa[r][k] = 8'(o + 1); pb[r][k] = 8'(o); pc[r][k] = 8'(o + 3); end
          2: begin pa[r][k] = 8'(o + 1); pb[r][k] = 8'(o + 1); pc[r][k] = 8'(o + 1); end
          3: begin pa[r][k] = 8'd255; pb[r][k] = 8'd255; pc[r][k] = 8'd255; end
          4: begin
            pa[r][k] = 8'(o + $urandom_range(0, 1) - $urandom_range(0, 1));
            pb[r][k] = 8'(o + $urandom_range(0, 1) - $urandom_range(0, 1));
            pc[r][k] = 8'(o + $urandom_range(0, 1) - $urandom_range(0, 1));
          end
          5: begin pa[r][k] = 8'(o + 2); pb[r][k] = 8'(o + 1); pc[r][k] = 8'(o + 1); end
          default: begin
            pa[r][k] = 8'($urandom_range(0, 255));
            pb[r][k] = 8'($urandom_range(0, 255));
            pc[r][k] = 8'($urandom_range(0, 255));
          end
        endcase
      end
    end
  endtask

  function automatic int absdiff(input logic [7:0] x, input logic [7:0] y);
    int d = int'(x) - int'(y);
    return (d < 0) ? -d : d;
  endfunction

  // Reference: total SAD per candidate over the whole block, first minimum wins.
  task automatic model();
    int s[3];
    s = '{0, 0, 0};
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        s[0] += absdiff(pa[r][k], po[r][k]);
        s[1] += absdiff(pb[r][k], po[r][k]);
        s[2] += absdiff(pc[r][k], po[r][k]);
      end
    end
    exp_idx = 0;
    exp_sad = s[0];
    for (int i = 1; i < 3; i++) begin
      if (s[i] < exp_sad) begin
        exp_idx = i;
        exp_sad = s[i];
      end
    end
  endtask

  task automatic beat(input int r, input bit with_start);
    for (int k = 0; k < 8; k++) begin
      cand_a[k*8 +: 8] = pa[r][k];
      cand_b[k*8 +: 8] = pb[r][k];
      cand_c[k*8 +: 8] = pc[r][k];
      orig[k*8 +: 8]   = po[r][k];
    end
    valid = 1'b1;
    start = with_start;
    tick();
    valid = 1'b0;
    start = 1'b0;
    scramble();
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
  endtask

  // Full search; done is due on the 2nd cycle after the final beat's edge.
  task automatic run_search(input string tag, input int gap_max, input bit inject);
    model();
    do_start(tag);
    for (int r = 0; r < 8; r++) begin
      int gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        scramble();
        tick();
        check({tag, "_busy_gap"}, 32'(busy), 32'd1);
      end
      beat(r, inject && (r == 3));
`ifdef FME_SAD_PROTOCOL_CHECK_EN
      if (inject && (r == 3)) check({tag, "_proto_err_hi"}, 32'(proto_err), 32'd1);
      if (inject && (r == 4)) check({tag, "_proto_err_lo"}, 32'(proto_err), 32'd0);
`endif
    end
    check({tag, "_done_cmp"}, 32'(done), 32'd0);
    check({tag, "_busy_cmp"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_best_idx"}, 32'(best_idx), 32'(exp_idx));
    check({tag, "_best_sad"}, 32'(best_sad), 32'(exp_sad));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sad_hold"}, 32'(best_sad), 32'(exp_sad));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    scramble();
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(best_idx), 32'd0);
    check("rst_sad", 32'(best_sad), 32'd0);
`ifdef FME_SAD_PROTOCOL_CHECK_EN
    check("rst_proto_err", 32'(proto_err), 32'd0);
`endif

    // valid in IDLE must not start or disturb anything
    valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    check("idle_valid_busy", 32'(busy), 32'd0);

    gen(1);
    run_search("offset", 0, 1'b0);
    check("offset_idx_const", 32'(best_idx), 32'd1);
    check("offset_sad_const", 32'(best_sad), 32'd0);

    gen(2);
    run_search("tie_all", 0, 1'b0);
    check("tie_all_idx_const", 32'(best_idx), 32'd0);
    check("tie_all_sad_const", 32'(best_sad), 32'd64);

    gen(3);
    run_search("max", 0, 1'b0);
    check("max_sad_const", 32'(best_sad), 32'd16320);

    gen(5);
    run_search("tie_bc", 0, 1'b0);
    check("tie_bc_idx_const", 32'(best_idx), 32'd1);

    // same data back-to-back and gapped must agree
    gen(0);
    run_search("b2b", 0, 1'b0);
    save_idx = int'(best_idx);
    save_sad = int'(best_sad);
    run_search("gapped", 5, 1'b0);
    check("gapped_vs_b2b_idx", 32'(best_idx), 32'(save_idx));
    check("gapped_vs_b2b_sad", 32'(best_sad), 32'(save_sad));

    gen(0);
    run_search("start_in_acc", 2, 1'b1);

    // reset mid-search: no done, then a clean search
    gen(0);
    do_start("abort");
    for (int r = 0; r < 4; r++) beat(r, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sad", 32'(best_sad), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    gen(0);
    run_search("after_abort", 1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      gen((t % 2 == 0) ? 0 : 4);
      run_search($sformatf("rand%0d", t), $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
